// File: rtl/alu_issue_ctrl.sv
// Single-issue front end for the TotalALU datapath: issues one R-type op,
// holds Signal/operands for the op's latency, returns the captured Output.
module alu_issue_ctrl #(
    parameter int          EXEC_LAT   = 1,
    parameter int          MUL_CYCLES = 32,
    parameter int          HILO_LAT   = 1,
    parameter logic [5:0]  IDLE_SIG   = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [5:0]  funct,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [5:0]  Signal,
    output logic [31:0] dataA,
    output logic [31:0] dataB,
    input  logic [31:0] alu_out,
    output logic [31:0] result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        result_err,
    output logic        mul_busy,
    output logic        mul_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;

    localparam int CNT_W = 16;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             singleCycleOp;

    // Ops that complete within EXEC_LAT cycles (everything but MULTU).
    always_comb begin
        singleCycleOp = 1'b0;
        case (funct)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_MFHI, F_MFLO: singleCycleOp = 1'b1;
            default: singleCycleOp = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            Signal       <= IDLE_SIG;
            dataA        <= '0;
            dataB        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            result_err   <= 1'b0;
            mul_busy     <= 1'b0;
            mul_done     <= 1'b0;
            instr_ready  <= 1'b1;
        end else begin
            mul_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_ready <= 1'b0;
                        if (funct == F_MULTU) begin
                            Signal   <= F_MULTU;
                            dataA    <= op_a;
                            dataB    <= op_b;
                            mul_busy <= 1'b1;
                            cnt      <= CNT_W'(MUL_CYCLES + HILO_LAT - 1);
                            state    <= MUL;
                        end else if (singleCycleOp) begin
                            Signal <= funct;
                            dataA  <= op_a;
                            dataB  <= op_b;
                            cnt    <= CNT_W'(EXEC_LAT - 1);
                            state  <= EXEC;
                        end else begin
                            result       <= '0;
                            result_err   <= 1'b1;
                            result_valid <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        result       <= alu_out;
                        result_err   <= 1'b0;
                        result_valid <= 1'b1;
                        Signal       <= IDLE_SIG;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MUL: begin
                    // No result handshake: completion is signalled by mul_done only.
                    if (cnt == '0) begin
                        mul_busy    <= 1'b0;
                        mul_done    <= 1'b1;
                        Signal      <= IDLE_SIG;
                        instr_ready <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        result_err   <= 1'b0;
                        instr_ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural TotalALU model
// (combinational Output, HiLo written after MUL_CYCLES+HILO_LAT MULTU cycles).
module tb_alu_issue_ctrl;

    localparam int MULC = 32;
    localparam int HLAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [5:0]  funct = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [5:0]  Signal;
    logic [31:0] dataA, dataB, alu_out, result;
    logic        result_valid, result_err, mul_busy, mul_done;
    logic        result_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    alu_issue_ctrl #(.EXEC_LAT(1), .MUL_CYCLES(MULC), .HILO_LAT(HLAT), .IDLE_SIG(6'b111111)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .funct(funct), .op_a(op_a), .op_b(op_b), .Signal(Signal), .dataA(dataA), .dataB(dataB),
        .alu_out(alu_out), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .result_err(result_err),
        .mul_busy(mul_busy), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    // Datapath model
    logic [31:0] hi = '0, lo = '0;
    int mulCnt = 0;
    always @(posedge clk) begin
        if (reset) begin
            hi <= '0; lo <= '0; mulCnt <= 0;
        end else if (Signal == 6'd25) begin
            mulCnt <= mulCnt + 1;
            if (mulCnt + 1 == MULC + HLAT) {hi, lo} <= {32'd0, dataA} * {32'd0, dataB};
        end else begin
            mulCnt <= 0;
        end
    end

    always_comb begin
        alu_out = '0;
        case (Signal)
            6'd36: alu_out = dataA & dataB;
            6'd37: alu_out = dataA | dataB;
            6'd32: alu_out = dataA + dataB;
            6'd34: alu_out = dataA - dataB;
            6'd42: alu_out = {31'd0, $signed(dataA) < $signed(dataB)};
            6'd0:  alu_out = dataA << dataB[4:0];
            6'd16: alu_out = hi;
            6'd18: alu_out = lo;
            default: alu_out = '0;
        endcase
    end

    always @(negedge clk) if (result_valid && mul_done) overlap++;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        instr_valid = 1'b1; funct = f; op_a = a; op_b = b;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic waitResult(input string tag);
        int n = 0;
        while (result_valid !== 1'b1 && n < 50) begin tick(); n++; end
        chk({tag, "_arrive"}, {31'd0, result_valid}, 32'd1);
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_sig"}, {26'd0, Signal}, 32'h3F);
        chk({tag, "_dA"}, dataA, 32'd0);
        chk({tag, "_dB"}, dataB, 32'd0);
        chk({tag, "_res"}, result, 32'd0);
        chk({tag, "_flags"}, {27'd0, result_valid, result_err, mul_busy, mul_done, instr_ready}, 32'b00001);
    endtask

    initial begin
        int busyCnt, doneSeen, readySeen;
        tick(); tick();
        reset = 1'b0;
        chkReset("reset");

        // ADD 5+7 with full timing
        issue(6'd32, 32'd5, 32'd7);
        chk("add_sig", {26'd0, Signal}, 32'd32);
        chk("add_dA", dataA, 32'd5);
        chk("add_rdy0", {31'd0, instr_ready}, 32'd0);
        tick();
        chk("add_rv", {31'd0, result_valid}, 32'd1);
        chk("add_res", result, 32'd12);
        chk("add_err", {31'd0, result_err}, 32'd0);
        tick();
        chk("add_rdy1", {31'd0, instr_ready}, 32'd1);
        chk("add_rv0", {31'd0, result_valid}, 32'd0);

        // SUB then SLT
        issue(6'd34, 32'd3, 32'd5);
        waitResult("sub");
        chk("sub_res", result, 32'hFFFF_FFFE);
        chk("sub_err", {31'd0, result_err}, 32'd0);
        tick();
        chk("between_sig", {26'd0, Signal}, 32'h3F);
        issue(6'd42, 32'd3, 32'd5);
        waitResult("slt");
        chk("slt_res", result, 32'd1);
        tick();

        // MULTU then MFHI/MFLO
        issue(6'd25, 32'hFFFF_FFFF, 32'd2);
        busyCnt = 0; doneSeen = 0; readySeen = 0;
        while (mul_busy === 1'b1 && busyCnt < 100) begin
            busyCnt++;
            if (mul_done) doneSeen++;
            if (instr_ready) readySeen++;
            if (Signal != 6'd25) readySeen++;
            tick();
        end
        chk("mul_busy_len", busyCnt, 32'd33);
        chk("mul_early", doneSeen + readySeen, 32'd0);
        chk("mul_done", {31'd0, mul_done}, 32'd1);
        chk("mul_rdy", {31'd0, instr_ready}, 32'd1);
        chk("mul_sig", {26'd0, Signal}, 32'h3F);
        tick();
        chk("mul_done_pulse", {31'd0, mul_done}, 32'd0);
        issue(6'd16, 32'd0, 32'd0);
        waitResult("mfhi");
        chk("mfhi_res", result, 32'd1);
        tick();
        issue(6'd18, 32'd0, 32'd0);
        waitResult("mflo");
        chk("mflo_res", result, 32'hFFFF_FFFE);
        tick();

        // Backpressure on OR
        result_ready = 1'b0;
        issue(6'd37, 32'hF0, 32'h0F);
        waitResult("or");
        for (int i = 0; i < 5; i++) begin
            instr_valid = 1'b1; funct = 6'd32; op_a = 32'h55; op_b = 32'h66;
            chk("bp_res", result, 32'hFF);
            chk("bp_flags", {30'd0, result_valid, instr_ready}, 32'b10);
            tick();
        end
        instr_valid = 1'b0;
        result_ready = 1'b1;
        tick();
        chk("bp_done", {30'd0, result_valid, instr_ready}, 32'b01);
        chk("bp_ignored", dataA, 32'hF0);
        chk("bp_sig", {26'd0, Signal}, 32'h3F);

        // Unsupported funct
        issue(6'd3, 32'd9, 32'd9);
        chk("bad_flags", {29'd0, result_valid, result_err, mul_busy}, 32'b110);
        chk("bad_res", result, 32'd0);
        chk("bad_sig", {26'd0, Signal}, 32'h3F);
        tick();
        chk("bad_clear", {29'd0, result_valid, result_err, instr_ready}, 32'b001);

        // Reset in the middle of MULTU
        issue(6'd25, 32'd3, 32'd4);
        for (int i = 0; i < 9; i++) tick();
        chk("abort_busy", {31'd0, mul_busy}, 32'd1);
        reset = 1'b1;
        tick();
        chkReset("abort");
        reset = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (mul_done) doneSeen++;
            tick();
        end
        chk("abort_nodone", doneSeen, 32'd0);
        issue(6'd32, 32'd1, 32'd1);
        waitResult("add2");
        chk("add2_res", result, 32'd2);
        tick();
        issue(6'd18, 32'd0, 32'd0);
        waitResult("mflo_rst");
        chk("mflo_rst_res", result, 32'd0);
        tick();

        // SLL through the datapath
        issue(6'd0, 32'd1, 32'd4);
        waitResult("sll");
        chk("sll_res", result, 32'd16);
        tick();

        chk("done_rv_overlap", overlap, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Single-issue front end that drives the TotalALU datapath.
- Accepts one R-type operation per handshake (funct plus two operands), drives Signal/dataA/dataB, holds them for the required latency, captures the ALU Output and returns it through a valid/ready result port.
- Sequences multi-cycle MULTU, so that MFHI/MFLO issued afterwards read the updated HiLo.
- Rejects unsupported funct codes with an error flag.

Parameters:
- EXEC_LAT, 1: cycles Signal is held before alu_out is sampled for AND/OR/ADD/SUB/SLT/SLL/MFHI/MFLO (min 1).
- MUL_CYCLES, 32: cycles Signal is held at MULTU for the multiplier to finish.
- HILO_LAT, 1: extra MULTU cycles allowing HiLo to capture the product.
- IDLE_SIG, 6'b111111: Signal value driven when no operation is in flight.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- instr_valid  in  1  operation offered
- instr_ready  out  1  block can accept an operation
- funct  in  6  function code
- op_a  in  32  operand A
- op_b  in  32  operand B
- Signal  out  6  function code to the datapath
- dataA  out  32  operand A to the datapath
- dataB  out  32  operand B to the datapath
- alu_out  in  32  datapath Output
- result  out  32  captured result
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts the result
- result_err  out  1  qualifies result_valid: unsupported funct
- mul_busy  out  1  MULTU in flight
- mul_done  out  1  one-cycle pulse at MULTU completion

Behaviour:
- Reset (synchronous, active-high) values:
  - state=IDLE; Signal=IDLE_SIG; dataA=dataB=0; result=0.
  - result_valid=0; result_err=0; mul_busy=0; mul_done=0; instr_ready=1.
  - Reset asserted mid-operation aborts it; no result or mul_done is produced.
- All outputs are registered. instr_ready=1 only in IDLE.
- Supported funct codes: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SLL 0, MULTU 25, MFHI 16, MFLO 18.
- Accept occurs on an edge with instr_valid && instr_ready. funct/op_a/op_b are ignored at any other time.
- States:
  - IDLE:
    - Accept of a supported non-MULTU funct -> EXEC. Signal<=funct, dataA<=op_a, dataB<=op_b, cnt<=EXEC_LAT-1.
    - Accept of MULTU -> MUL. Signal<=MULTU, operands latched, mul_busy<=1, cnt<=MUL_CYCLES+HILO_LAT-1.
    - Accept of an unsupported funct -> RESP. result<=0, result_err<=1, result_valid<=1. Signal stays IDLE_SIG.
  - EXEC:
    - Signal/dataA/dataB are held stable.
    - When cnt==0: result<=alu_out, result_err<=0, result_valid<=1, Signal<=IDLE_SIG, -> RESP.
    - Otherwise cnt decrements.
  - MUL:
    - Signal/dataA/dataB are held stable for exactly MUL_CYCLES+HILO_LAT cycles.
    - When cnt==0: mul_busy<=0, mul_done<=1 for one cycle, Signal<=IDLE_SIG, -> IDLE.
    - No result handshake occurs for MULTU.
  - RESP:
    - result/result_err/result_valid are held unchanged while result_ready=0.
    - On an edge with result_ready=1: result_valid<=0, result_err<=0, -> IDLE.
- Latency, with EXEC_LAT=1 and accept at edge 0: Signal valid from edge 1, result_valid high from edge 2.
  - Best-case throughput is one operation per EXEC_LAT+2 cycles (the accept cycle, EXEC_LAT execute cycles, and a result-handshake cycle when result_ready is held high).
- MULTU accepted at edge 0: mul_busy is high from edge 1 to edge 1+MUL_CYCLES+HILO_LAT, where mul_done pulses and instr_ready returns to 1.
  - MFHI/MFLO therefore cannot issue before HiLo is updated.
- dataA/dataB keep their last values after an operation completes; only reset clears them.
- MFHI/MFLO before any MULTU since reset are legal and return the HiLo reset value, 0.
- mul_done and result_valid are never asserted in the same cycle.

Test Plan:
- ADD, op_a=5, op_b=7, result_ready=1, EXEC_LAT=1:
  - Signal=32 on cycle 1; result=12, result_valid=1 on cycle 2; instr_ready=1 on cycle 3.
- SUB 3-5, then SLT(3,5):
  - result=0xFFFFFFFE with result_err=0; then result=1.
  - Signal returns to IDLE_SIG between the two operations.
- MULTU 0xFFFFFFFF*2, then MFHI, then MFLO:
  - mul_busy high for 33 cycles; mul_done pulses once; instr_ready low throughout.
  - MFHI result=0x00000001; MFLO result=0xFFFFFFFE.
- Backpressure: result_ready held 0 for 5 cycles after result_valid on an OR(0xF0,0x0F):
  - result=0xFF stable, instr_ready=0, instr_valid ignored.
  - Completes one edge after result_ready=1.
- Unsupported funct=3:
  - result_valid=1, result_err=1, result=0.
  - Signal stays IDLE_SIG, mul_busy=0.
- Reset asserted at cycle 10 of a MULTU:
  - Next edge: all outputs at reset values, instr_ready=1, no mul_done pulse.
  - A following ADD(1,1) returns 2.
